// File: rtl/pin_display_scanner.sv
// Time-multiplexed 8-digit seven-segment driver for the lock's PIN entry and status display.
// Shows entered digits (or dashes), status words, and blinks denied/lockout messages.
module pin_display_scanner #(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digits_in,
   input  logic [3:0]  digit_count,
   input  logic        mask_en,
   input  logic [1:0]  status,
   output logic [6:0]  seg_out,
   output logic [7:0]  an_out,
   output logic [2:0]  scan_idx
);

   localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [1:0] ST_ENTRY    = 2'b00;
   localparam logic [1:0] ST_UNLOCKED = 2'b01;
   localparam logic [1:0] ST_DENIED   = 2'b10;
   localparam logic [1:0] ST_LOCKOUT  = 2'b11;

   logic [PW-1:0] r_prescale;
   logic [FW-1:0] r_frame;
   logic          r_blinkOn;
   logic [1:0]    r_statusPrev;

   logic          w_scanTick;
   logic          w_frameTick;
   logic          w_statusChg;
   logic          w_blinkEff;
   logic [3:0]    w_count;
   logic [3:0]    w_digit;
   logic [6:0]    w_seg;
   logic [7:0]    w_an;

   assign w_scanTick  = (r_prescale == PW'(SCAN_DIV - 1));
   assign w_frameTick = w_scanTick && (scan_idx == 3'd7);
   assign w_statusChg = (status != r_statusPrev);
   // A status change restarts the blink in the ON phase on this very edge,
   // so the new message is never hidden by a stale OFF phase.
   assign w_blinkEff  = w_statusChg | r_blinkOn;
   assign w_count     = (digit_count > 4'd8) ? 4'd8 : digit_count;
   assign w_digit     = 4'(digits_in >> {~scan_idx, 2'b00});

   function automatic logic [6:0] bcdToSeg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   always_comb begin
      w_seg = 7'h00;
      case (status)
         ST_ENTRY: begin
            if ({1'b0, scan_idx} < w_count)
               w_seg = mask_en ? 7'h40 : bcdToSeg(w_digit);
         end
         ST_UNLOCKED: begin
            case (scan_idx)
               3'd0:    w_seg = 7'h3F;
               3'd1:    w_seg = 7'h73;
               3'd2:    w_seg = 7'h79;
               3'd3:    w_seg = 7'h54;
               default: w_seg = 7'h00;
            endcase
         end
         ST_DENIED: begin
            case (scan_idx)
               3'd0:    w_seg = 7'h79;
               3'd1:    w_seg = 7'h50;
               3'd2:    w_seg = 7'h50;
               default: w_seg = 7'h00;
            endcase
         end
         ST_LOCKOUT: w_seg = 7'h40;
         default:    w_seg = 7'h00;
      endcase
   end

   assign w_an = (status[1] && !w_blinkEff) ? 8'hFF : ~(8'h01 << scan_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale   <= '0;
         scan_idx     <= 3'd0;
         r_frame      <= '0;
         r_blinkOn    <= 1'b1;
         r_statusPrev <= status;
         seg_out      <= 7'h00;
         an_out       <= 8'hFF;
      end else begin
         r_statusPrev <= status;
         seg_out      <= w_seg;
         an_out       <= w_an;

         if (w_scanTick) begin
            r_prescale <= '0;
            scan_idx   <= scan_idx + 3'd1;
         end else begin
            r_prescale <= r_prescale + PW'(1);
         end

         if (w_statusChg) begin
            r_frame   <= '0;
            r_blinkOn <= 1'b1;
         end else if (w_frameTick) begin
            if (r_frame == FW'(BLINK_DIV - 1)) begin
               r_frame   <= '0;
               r_blinkOn <= ~r_blinkOn;
            end else begin
               r_frame <= r_frame + FW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pin_display_scanner.sv
// Scoreboard bench for pin_display_scanner: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_pin_display_scanner;

   localparam logic [55:0] TAB_ENTRY  = {7'h5B, 7'h06, 7'h6F, 7'h4F, 7'h6D, 7'h66, 7'h7F, 7'h7F};
   localparam logic [55:0] TAB_MASK3  = {7'h40, 7'h40, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   localparam logic [55:0] TAB_DASH   = {8{7'h40}};
   localparam logic [55:0] TAB_BLANK  = {8{7'h00}};
   localparam logic [55:0] TAB_HEX    = {7'h00, 7'h06, 7'h00, 7'h3F, 7'h07, 7'h00, 7'h7D, 7'h00};
   localparam logic [55:0] TAB_OPEN   = {7'h3F, 7'h73, 7'h79, 7'h54, 7'h00, 7'h00, 7'h00, 7'h00};
   localparam logic [55:0] TAB_ERR    = {7'h79, 7'h50, 7'h50, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   typedef struct {
      int         cyc;
      logic [6:0] seg;
      logic [7:0] an;
      logic [2:0] idx;
      bit         segCare;
      string      name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] digitsIn;
   logic [3:0]  digitCount;
   logic        maskEn;
   logic [1:0]  status;
   logic [6:0]  segOut;
   logic [7:0]  anOut;
   logic [2:0]  scanIdx;

   exp_t sb[$];
   int   cyc   = 0;
   int   rel   = 0;
   int   total = 0;
   int   bad   = 0;

   pin_display_scanner #(
      .SCAN_DIV (4),
      .BLINK_DIV(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digitsIn),
      .digit_count(digitCount),
      .mask_en    (maskEn),
      .status     (status),
      .seg_out    (segOut),
      .an_out     (anOut),
      .scan_idx   (scanIdx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scan position is derived from edges since reset release: 4 edges per digit.
   task automatic pushRange(input string name, input int c0, input int n,
                            input logic [55:0] tab, input bit dark);
      exp_t e;
      for (int c = c0; c < c0 + n; c++) begin
         int k;
         int p;
         k         = c - rel;
         p         = (k / 4) % 8;
         e.cyc     = c;
         e.seg     = tab[55 - 7 * p -: 7];
         e.an      = dark ? 8'hFF : ~(8'h01 << p);
         e.idx     = 3'(((k + 1) / 4) % 8);
         e.segCare = !dark;
         e.name    = name;
         sb.push_back(e);
      end
   endtask

   task automatic pushReset(input int c);
      exp_t e;
      e.cyc     = c;
      e.seg     = 7'h00;
      e.an      = 8'hFF;
      e.idx     = 3'd0;
      e.segCare = 1'b1;
      e.name    = "reset";
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [1:0] st, input logic m, input logic [3:0] cnt,
                                input logic [31:0] d, input string name,
                                input logic [55:0] tab, input bit dark, input int n);
      status     = st;
      maskEn     = m;
      digitCount = cnt;
      digitsIn   = d;
      pushRange(name, cyc + 1, n, tab, dark);
      repeat (n) @(negedge clk);
   endtask

   task automatic alignFrame();
      while (((cyc + 1 - rel) % 32) != 0) @(negedge clk);
   endtask

   task automatic checkOutput(input exp_t e);
      total++;
      if (e.cyc != cyc || anOut !== e.an || scanIdx !== e.idx ||
          (e.segCare && segOut !== e.seg)) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d: got seg=%h an=%h idx=%0d, want seg=%h an=%h idx=%0d (expCyc=%0d)",
                  e.name, cyc, segOut, anOut, scanIdx, e.seg, e.an, e.idx, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) checkOutput(sb.pop_front());
   end

   initial begin
      rst        = 1'b1;
      status     = 2'b00;
      maskEn     = 1'b0;
      digitCount = 4'd0;
      digitsIn   = 32'h0;
      for (int c = 1; c <= 3; c++) pushReset(c);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rel = cyc + 1;

      applyStimulus(2'b00, 1'b0, 4'd8,  32'h2193_5488, "entry",    TAB_ENTRY, 1'b0, 64);
      applyStimulus(2'b00, 1'b1, 4'd3,  32'h2193_5488, "mask3",    TAB_MASK3, 1'b0, 32);
      applyStimulus(2'b00, 1'b1, 4'd12, 32'h2193_5488, "mask12",   TAB_DASH,  1'b0, 32);
      applyStimulus(2'b00, 1'b0, 4'd1,  32'hA193_5488, "hexBlank", TAB_BLANK, 1'b0, 32);
      applyStimulus(2'b00, 1'b0, 4'd8,  32'hA1F0_7B6C, "hexMix",   TAB_HEX,   1'b0, 32);
      applyStimulus(2'b01, 1'b0, 4'd8,  32'hA1F0_7B6C, "open",     TAB_OPEN,  1'b0, 256);
      applyStimulus(2'b11, 1'b0, 4'd8,  32'hA1F0_7B6C, "lockout",  TAB_DASH,  1'b0, 32);
      applyStimulus(2'b00, 1'b0, 4'd8,  32'hA1F0_7B6C, "entry2",   TAB_HEX,   1'b0, 32);

      alignFrame();
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "errOn",   TAB_ERR,  1'b0, 64);
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "errOff",  TAB_ERR,  1'b1, 16);
      applyStimulus(2'b11, 1'b0, 4'd8, 32'hA1F0_7B6C, "lockMid", TAB_DASH, 1'b0, 32);

      alignFrame();
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "err2On",   TAB_ERR, 1'b0, 64);
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "err2Off",  TAB_ERR, 1'b1, 64);
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "err2Back", TAB_ERR, 1'b0, 64);
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "err2Off2", TAB_ERR, 1'b1, 22);

      rst = 1'b1;
      pushReset(cyc + 1);
      @(negedge clk);
      rst = 1'b0;
      rel = cyc + 1;
      applyStimulus(2'b10, 1'b0, 4'd8, 32'hA1F0_7B6C, "postReset", TAB_ERR, 1'b0, 32);

      for (int g = 0; g < 50 && sb.size() > 0; g++) @(negedge clk);
      if (sb.size() > 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pin_display_scanner.md
Name: pin_display_scanner

Overview:
- Read-out counterpart to the keypad encoder and shift-register digit store of the lock.
- Takes the 8 stored BCD digits (32 bits, digit 1 in the MSBs) plus the entry count and lock status.
- Drives a time-multiplexed 8-digit seven-segment display: digits, masked entry dashes, or status words, with blinking for error and lockout.

Parameters:
- SCAN_DIV, 4: clock cycles each digit position is held before advancing; must be ≥1.
- BLINK_DIV, 16: number of full 8-digit frames per blink half-period; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- digits_in  input  32  stored digits; position i uses bits [31-4i : 28-4i].
- digit_count  input  4  number of digits entered, 0..8; values >8 are treated as 8.
- mask_en  input  1  1 = show '-' instead of digit values.
- status  input  2  00 entry, 01 unlocked, 10 denied, 11 lockout.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- an_out  output  8  digit enables, active-low, one-hot-low, registered.
- scan_idx  output  3  current position 0..7, registered.

Behaviour:
- Reset (rst=1 at an edge):
  - scan_idx=0, prescaler=0, frame counter=0, blink phase=ON.
  - seg_out=7'h00, an_out=8'hFF.
  - Reset overrides everything, including mid-scan.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At terminal count it returns to 0 and scan_idx increments, wrapping 7→0.
- Frame and blink:
  - Each scan_idx wrap 7→0 increments the frame counter (0..BLINK_DIV-1).
  - At the frame counter's terminal count it returns to 0 and the blink phase toggles.
- Status change:
  - Any change of status between consecutive cycles clears the frame counter and forces blink phase ON in the same edge.
  - Prescaler and scan_idx are unaffected.
- Output timing:
  - seg_out/an_out are registered from the current scan_idx and current inputs, so they lag scan_idx by 1 cycle.
  - First post-reset cycle shows position 0: an_out=8'hFE.
- an_out:
  - Bit scan_idx is low, all others high.
  - Forced to 8'hFF when blink phase is OFF and status is 10 or 11.
- Decode, status 00 (entry):
  - Position i ≥ effective count: blank (00).
  - Otherwise, mask_en=1: '-'=40.
  - Otherwise, BCD: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - BCD 10..15 show blank (00).
- Decode, status 01 (unlocked):
  - Positions 0-3 show "OPEn": 3F, 73, 79, 54. Positions 4-7 blank.
  - No blinking.
- Decode, status 10 (denied):
  - Positions 0-2 show "Err": 79, 50, 50. Rest blank.
  - Blinks.
- Decode, status 11 (lockout):
  - All 8 positions show 40.
  - Blinks.
- Inputs may change at any cycle; the new value appears on the next registered output. No handshake is required.

Test Plan:
(SCAN_DIV=4, BLINK_DIV=2)
1. Reset:
   - Stimulus: rst=1 for 3 cycles, then release.
   - Response: during reset, seg_out=00, an_out=FF, scan_idx=0.
   - First cycle after release: an_out=FE.
   - scan_idx=1 after 4 clocks.
   - Wrap to 0 after 32 clocks.
2. Unmasked entry:
   - Stimulus: status=00, mask_en=0, digits_in=32'h2193_5488, digit_count=8.
   - Response: positions 0..7 give seg 5B, 06, 6F, 4F, 6D, 66, 7F, 7F.
   - an_out goes FE, FD, …, 7F.
3. Masked and partial entry:
   - mask_en=1, digit_count=3 → positions 0-2 seg 40, positions 3-7 seg 00.
   - digit_count=12 → all positions 40.
   - mask_en=0, digit_count=1, digits_in[31:28]=4'hA → position 0 seg 00.
4. Status words:
   - status=01 → 3F, 73, 79, 54, 00, 00, 00, 00, with no blink over 256 clocks.
   - status=11 → all 40.
5. Denied blink:
   - Stimulus: status 00→10.
   - Response: "Err" displayed (79, 50, 50) for frames 0-1 (64 clocks).
   - an_out=FF for the next 64 clocks, then visible again.
   - Changing status to 11 mid-OFF → display visible on the next cycle.
6. Reset mid-scan:
   - Stimulus: rst at scan_idx=5, status=10, blink OFF.
   - Response: next cycle scan_idx=0, an_out=FF, seg_out=00.
   - Cycle after release: an_out=FE, seg 79.
